// File: rtl/tz80_memctl.sv
// Memory controller between the Thumb Z80 core bus and byte-wide external memory.
// One memory transaction per core step, ROM write protection, read hit register, bus timeout.
module tz80_memctl #(
  parameter logic [15:0] ROM_TOP = 16'h3FFF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] c_address,
  input  logic [7:0]  c_wdata,
  input  logic        c_we,
  output logic [7:0]  c_rdata,
  output logic        locked,
  output logic [15:0] m_address,
  output logic [7:0]  m_wdata,
  output logic        m_we,
  output logic        m_req,
  input  logic        m_ack,
  input  logic [7:0]  m_rdata,
  input  logic        err_clr,
  output logic        rom_wr_err,
  output logic        bus_err,
  output logic [1:0]  state_dbg
);

  // Handshake: m_req is a level held with m_address/m_wdata/m_we stable until the
  // edge where m_ack is sampled high (one-cycle pulse, m_rdata valid with it) or the
  // request is aborted on timeout; m_ack is only looked at while m_req is high.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        hit_valid, hit_valid_nx;
  logic [15:0] hit_addr, hit_addr_nx;
  logic [7:0]  hit_data, hit_data_nx;
  logic [7:0]  c_rdata_nx;
  logic        locked_nx;
  logic [15:0] m_address_nx;
  logic [7:0]  m_wdata_nx;
  logic        m_we_nx;
  logic        m_req_nx;
  logic        rom_set;
  logic        bus_set;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    hit_valid_nx = hit_valid;
    hit_addr_nx  = hit_addr;
    hit_data_nx  = hit_data;
    c_rdata_nx   = c_rdata;
    m_address_nx = m_address;
    m_wdata_nx   = m_wdata;
    m_we_nx      = m_we;
    m_req_nx     = m_req;
    rom_set      = 1'b0;
    bus_set      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (c_we) begin
          if (c_address <= ROM_TOP) begin
            rom_set  = 1'b1;
            state_nx = ST_DONE;
          end else begin
            m_address_nx = c_address;
            m_wdata_nx   = c_wdata;
            m_we_nx      = 1'b1;
            m_req_nx     = 1'b1;
            cnt_nx       = 8'd0;
            state_nx     = ST_REQ;
          end
        end else if (hit_valid && (c_address == hit_addr)) begin
          c_rdata_nx = hit_data;
          state_nx   = ST_DONE;
        end else begin
          m_address_nx = c_address;
          m_we_nx      = 1'b0;
          m_req_nx     = 1'b1;
          cnt_nx       = 8'd0;
          state_nx     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_ack) begin
          m_req_nx = 1'b0;
          m_we_nx  = 1'b0;
          state_nx = ST_DONE;
          if (m_we) begin
            // Write-through keeps the hit register coherent with memory.
            if (m_address == hit_addr) hit_data_nx = m_wdata;
          end else begin
            c_rdata_nx   = m_rdata;
            hit_addr_nx  = m_address;
            hit_data_nx  = m_rdata;
            hit_valid_nx = 1'b1;
          end
        end else if (cnt == TO_LAST) begin
          m_req_nx     = 1'b0;
          m_we_nx      = 1'b0;
          bus_set      = 1'b1;
          hit_valid_nx = 1'b0;
          state_nx     = ST_DONE;
          if (!m_we) c_rdata_nx = 8'hFF;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    locked_nx = (state_nx == ST_DONE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      hit_valid  <= 1'b0;
      hit_addr   <= 16'd0;
      hit_data   <= 8'd0;
      c_rdata    <= 8'd0;
      locked     <= 1'b0;
      m_address  <= 16'd0;
      m_wdata    <= 8'd0;
      m_we       <= 1'b0;
      m_req      <= 1'b0;
      rom_wr_err <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      hit_valid  <= hit_valid_nx;
      hit_addr   <= hit_addr_nx;
      hit_data   <= hit_data_nx;
      c_rdata    <= c_rdata_nx;
      locked     <= locked_nx;
      m_address  <= m_address_nx;
      m_wdata    <= m_wdata_nx;
      m_we       <= m_we_nx;
      m_req      <= m_req_nx;
      // A set on the same edge as a clear wins.
      rom_wr_err <= rom_set | (rom_wr_err & ~err_clr);
      bus_err    <= bus_set | (bus_err & ~err_clr);
    end
  end

  assign state_dbg = state;

endmodule
